ps2_scan_receiver: RTL and testbench



---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_scan_receiver_if.sv | 22 ++
 rtl/ps2_glitch_filter.sv | 45 ++++
 rtl/ps2_scan_receiver.sv | 162 ++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    // A frame's 8 data bits plus parity must carry an odd number of ones.
    function automatic logic odd_ones(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Pin and decoded-output bundle between the keyboard pins, receiver and keyboard buffer.
interface ps2_scan_receiver_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan;
    logic       extended;
    logic       scan_valid;
    logic       shift;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  scan, extended, scan_valid, shift, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output scan, extended, scan_valid, shift, frame_err
    );

endinterface

// File: rtl/ps2_glitch_filter.sv
// 2-FF synchronizer plus run-length filter: the level flips only after FILTER_LEN equal samples.
module ps2_glitch_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    localparam logic [7:0] LastCnt = 8'(FILTER_LEN - 1);

    logic [1:0] r_sync;
    logic       r_level;
    logic [7:0] r_cnt;
    logic       w_sync;
    logic       w_flip;

    assign w_sync = r_sync[1];
    assign w_flip = (w_sync != r_level) && (r_cnt == LastCnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            if (w_sync == r_level) begin
                r_cnt <= 8'd0;
            end else if (w_flip) begin
                r_cnt   <= 8'd0;
                r_level <= w_sync;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_level = r_level;
    // Combinational so the frame FSM acts in the same cycle the filtered level drops.
    assign o_fall  = w_flip & r_level;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decode and shift tracking.
// Optional PS2_TIMEOUT_EN aborts a stalled frame after TIMEOUT_CYCLES without a clock edge.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic                clk,
    input logic                reset,
    ps2_scan_receiver_if.slave bus
);

    logic       w_clk_level;
    logic       w_fall;
    logic       w_data;
    logic       w_abort;
    logic [1:0] r_data_sync;

    ps2_state_e r_state, w_state_next;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_sr;
    logic       r_par, r_stop, r_done, r_abort;
    logic       r_ext, r_brk, r_lshift, r_rshift;
    logic [7:0] r_scan;
    logic       r_extended, r_scan_valid, r_frame_err;

    ps2_glitch_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (bus.ps2_clk),
        .o_level(w_clk_level),
        .o_fall (w_fall)
    );

    assign w_data = r_data_sync[1];

`ifdef PS2_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_to_cnt;
    logic        r_lvl_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt   <= 32'd0;
            r_lvl_prev <= 1'b1;
        end else begin
            r_lvl_prev <= w_clk_level;
            if (r_state == IDLE || w_clk_level != r_lvl_prev) r_to_cnt <= 32'd0;
            else                                               r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
    logic w_unused_level;
    assign w_unused_level = w_clk_level;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                IDLE:    if (!w_data) w_state_next = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_state_next = PARITY;
                PARITY:  w_state_next = STOP;
                STOP:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
`ifdef PS2_TIMEOUT_EN
        else if (r_state != IDLE && r_to_cnt == TimeoutLast) begin
            w_state_next = IDLE;
            w_abort      = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_sync <= 2'b11;
            r_bit_cnt   <= 3'd0;
            r_sr        <= 8'd0;
            r_par       <= 1'b0;
            r_stop      <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_data_sync <= {r_data_sync[0], bus.ps2_data};
            r_done      <= w_fall && (r_state == STOP);
            r_abort     <= w_abort;
            if (w_fall) begin
                case (r_state)
                    IDLE:    r_bit_cnt <= 3'd0;
                    DATA: begin
                        r_sr      <= {w_data, r_sr[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    PARITY:  r_par  <= w_data;
                    STOP:    r_stop <= w_data;
                    default: ;
                endcase
            end
        end
    end

    // Byte decode runs the cycle after the stop edge (or timeout abort).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_lshift     <= 1'b0;
            r_rshift     <= 1'b0;
            r_scan       <= 8'd0;
            r_extended   <= 1'b0;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_abort || (r_done && !(r_stop && odd_ones({r_sr, r_par})))) begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end else if (r_done) begin
                if (r_sr == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_sr == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (r_sr == PS2_LSHIFT || r_sr == PS2_RSHIFT) begin
                        if (!r_ext) begin
                            if (r_sr == PS2_LSHIFT) r_lshift <= !r_brk;
                            else                    r_rshift <= !r_brk;
                        end
                    end else if (!r_sr[7] && !r_brk) begin
                        r_scan       <= r_sr;
                        r_extended   <= r_ext;
                        r_scan_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.scan       = r_scan;
    assign bus.extended   = r_extended;
    assign bus.scan_valid = r_scan_valid;
    assign bus.shift      = r_lshift | r_rshift;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: directed scenarios plus randomized key streams.
module tb_ps2_scan_receiver;

    localparam int unsigned FL = 8;
    localparam int unsigned TO = 1000;
    localparam int          H  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_scan_receiver_if bus ();

    ps2_scan_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_valid = 0, n_err = 0, n_both = 0;
    int valid_cyc = 0, last_fall = 0;

    // Reference model state.
    bit m_ext, m_brk, m_ls, m_rs, m_extd;
    logic [7:0] m_scan;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.scan_valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (bus.frame_err) n_err++;
        if (bus.scan_valid && bus.frame_err) n_both++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_extd = 0; m_scan = 8'h00;
    endtask

    // Expected reaction to one frame, straight from the byte rules.
    task automatic model_byte(input logic [7:0] b, input bit good, output bit ev, output bit ee);
        ev = 0;
        ee = 0;
        if (!good) begin
            ee = 1; m_ext = 0; m_brk = 0;
            return;
        end
        if (b == 8'hE0) begin m_ext = 1; return; end
        if (b == 8'hF0) begin m_brk = 1; return; end
        if (b == 8'h12 || b == 8'h59) begin
            if (!m_ext) begin
                if (b == 8'h12) m_ls = !m_brk;
                else            m_rs = !m_brk;
            end
        end else if (b < 8'h80 && !m_brk) begin
            m_scan = b; m_extd = m_ext; ev = 1;
        end
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic send_bit(input bit v);
        bus.ps2_data = v;
        wait_cyc(H);
        bus.ps2_clk = 1'b0;
        last_fall = cyc;
        wait_cyc(H);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits);
        logic [10:0] f;
        f = {~bad_stop, ~^b ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
    endtask

    task automatic do_byte(input string tag, input logic [7:0] b, input bit bad_par,
                           input bit bad_stop);
        int nv, ne;
        bit ev, ee;
        nv = n_valid;
        ne = n_err;
        send_bits(b, bad_par, bad_stop, 11);
        wait_cyc(4);
        model_byte(b, !(bad_par || bad_stop), ev, ee);
        chk({tag, ".valid"}, n_valid - nv, 32'(ev));
        chk({tag, ".err"}, n_err - ne, 32'(ee));
        chk({tag, ".scan"}, bus.scan, m_scan);
        chk({tag, ".ext"}, bus.extended, m_extd);
        chk({tag, ".shift"}, bus.shift, m_ls | m_rs);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".scan"}, bus.scan, 0);
        chk({tag, ".ext"}, bus.extended, 0);
        chk({tag, ".valid"}, bus.scan_valid, 0);
        chk({tag, ".shift"}, bus.shift, 0);
        chk({tag, ".err"}, bus.frame_err, 0);
    endtask

    logic [7:0] garbage [4] = '{8'hAA, 8'hFA, 8'hFE, 8'hE1};

    initial begin
        int nv, ne;
        logic [7:0] code;
        bit ev, ee;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        model_reset();
        wait_cyc(5);
        chk_reset_vals("rst");
        reset = 1'b0;
        wait_cyc(5);

        do_byte("a_make", 8'h1C, 0, 0);
        chk("latency", valid_cyc - last_fall, FL + 3);

        do_byte("sh_press", 8'h12, 0, 0);
        do_byte("sh_a", 8'h1C, 0, 0);
        do_byte("sh_brk_pfx", 8'hF0, 0, 0);
        do_byte("sh_a_brk", 8'h1C, 0, 0);
        do_byte("sh_rel_pfx", 8'hF0, 0, 0);
        do_byte("sh_release", 8'h12, 0, 0);

        do_byte("e0_pfx", 8'hE0, 0, 0);
        do_byte("e0_75", 8'h75, 0, 0);
        do_byte("e0b_pfx", 8'hE0, 0, 0);
        do_byte("e0b_f0", 8'hF0, 0, 0);
        do_byte("e0b_75", 8'h75, 0, 0);

        do_byte("fake_pfx", 8'hE0, 0, 0);
        do_byte("fake_12", 8'h12, 0, 0);

        do_byte("bad_par", 8'h1C, 1, 0);
        do_byte("after_bad", 8'h1B, 0, 0);

        // Short clock glitches with data low must never start a frame.
        nv = n_valid;
        ne = n_err;
        bus.ps2_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(10);
            bus.ps2_clk = 1'b0;
            wait_cyc(3);
            bus.ps2_clk = 1'b1;
        end
        wait_cyc(10);
        chk("glitch.valid", n_valid - nv, 0);
        chk("glitch.err", n_err - ne, 0);
        do_byte("post_glitch", 8'h1C, 0, 0);

`ifdef PS2_TIMEOUT_EN
        do_byte("to_pfx", 8'hE0, 0, 0);
        nv = n_valid;
        ne = n_err;
        send_bits(8'h29, 0, 0, 5);
        wait_cyc(TO + 50);
        model_byte(8'h00, 0, ev, ee);
        chk("timeout.err", n_err - ne, 32'(ee));
        chk("timeout.valid", n_valid - nv, 0);
        do_byte("after_to", 8'h29, 0, 0);
`endif

        do_byte("mr_shift", 8'h12, 0, 0);
        do_byte("mr_make", 8'h4B, 0, 0);
        nv = n_valid;
        ne = n_err;
        send_bits(8'h33, 0, 0, 5);
        reset = 1'b1;
        wait_cyc(3);
        chk_reset_vals("midrst");
        reset = 1'b0;
        model_reset();
        wait_cyc(3);
        chk("midrst.nerr", n_err - ne, 0);
        chk("midrst.nvalid", n_valid - nv, 0);
        do_byte("after_rst", 8'h33, 0, 0);

        for (int it = 0; it < 60; it++) begin
            code = 8'($urandom_range(1, 127));
            case ($urandom_range(0, 7))
                0: do_byte("r_make", code, 0, 0);
                1: begin
                    do_byte("r_brk_pfx", 8'hF0, 0, 0);
                    do_byte("r_brk", code, 0, 0);
                end
                2: begin
                    do_byte("r_ext_pfx", 8'hE0, 0, 0);
                    do_byte("r_ext", code, 0, 0);
                end
                3: begin
                    do_byte("r_eb_e0", 8'hE0, 0, 0);
                    do_byte("r_eb_f0", 8'hF0, 0, 0);
                    do_byte("r_eb", code, 0, 0);
                end
                4: begin
                    if ($urandom_range(0, 1) == 1) do_byte("r_sh_f0", 8'hF0, 0, 0);
                    do_byte("r_sh", ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59, 0, 0);
                end
                5: begin
                    do_byte("r_fake_e0", 8'hE0, 0, 0);
                    do_byte("r_fake", ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59, 0, 0);
                end
                6: do_byte("r_garbage", garbage[$urandom_range(0, 3)], 0, 0);
                default: begin
                    if ($urandom_range(0, 1) == 1) do_byte("r_pfx_err", 8'hE0, 0, 0);
                    if ($urandom_range(0, 1) == 1) do_byte("r_bad_par", code, 1, 0);
                    else                           do_byte("r_bad_stop", code, 0, 1);
                end
            endcase
        end

        chk("exclusive", n_both, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
